// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: shared types for the register snapshot streamer.
// Default widths match the monocycle core's register unit.
package reg_dump_pkg;

    localparam int XLEN_D  = 32;
    localparam int NREGS_D = 32;
    localparam int CYC_W_D = 32;
    localparam int OVF_W_D = 16;
    localparam int IDX_W   = $clog2(NREGS_D);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SCAN
    } state_t;

    typedef struct packed {
        logic [CYC_W_D-1:0] cycle;
        logic [IDX_W-1:0]   idx;
        logic [XLEN_D-1:0]  data;
        logic               last;
    } beat_t;

endpackage

// File: rtl/mask_next_idx.sv
// mask_next_idx: lowest-set-bit finder over a pending-register mask.
// only_one marks the final beat of a dump.
module mask_next_idx #(
    parameter int N = 32,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] mask,
    output logic [W-1:0] idx,
    output logic         found,
    output logic         only_one
);

    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = W'(i);
            end
        end
    end

    assign found    = |mask;
    assign only_one = found && ((mask & (mask - N'(1))) == '0);

endmodule

// File: rtl/reg_dump_unit.sv
// reg_dump_unit: periodic register-file snapshot, streamed as
// valid/ready beats (full dump or changed registers only).
module reg_dump_unit
    import reg_dump_pkg::*;
#(
    parameter int XLEN  = XLEN_D,
    parameter int NREGS = NREGS_D,
    parameter int CYC_W = CYC_W_D,
    parameter int OVF_W = OVF_W_D
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     delta,
    input  logic [CYC_W-1:0]         period,
    input  logic [NREGS*XLEN-1:0]    regs_flat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CYC_W-1:0]         out_cycle,
    output logic [$clog2(NREGS)-1:0] out_idx,
    output logic [XLEN-1:0]          out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic [OVF_W-1:0]         overruns
);

    localparam int IW = $clog2(NREGS);

    state_t           state;
    state_t           state_nx;
    logic [CYC_W-1:0] cyc;
    logic [CYC_W-1:0] dcnt;
    logic [CYC_W-1:0] reload;
    logic [CYC_W-1:0] cap_cycle;
    logic             trig;
    logic             hs;
    logic             primed;
    logic [NREGS-1:0] mask;
    logic [NREGS-1:0] mask_cap;
    logic [NREGS-1:0] mask_nx;
    logic [XLEN-1:0]  shadow [NREGS];
    logic [XLEN-1:0]  regs_a [NREGS];
    logic [IW-1:0]    nx_idx;
    logic             nx_found;
    logic             nx_one;
    logic [XLEN-1:0]  nx_data;

    assign reload = (period == '0) ? '0 : period - CYC_W'(1);
    assign trig   = en && (dcnt == '0);
    assign hs     = out_valid && out_ready;
    assign busy   = (state != IDLE);

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_a[i] = regs_flat[i*XLEN +: XLEN];
        end
    end

    // Until the first capture the shadow is meaningless, so force a full dump.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            mask_cap[i] = !primed || !delta || (regs_a[i] != shadow[i]);
        end
    end

    always_comb begin
        state_nx = state;
        mask_nx  = mask;
        unique case (state)
            IDLE: begin
                if (trig) begin
                    state_nx = CAPTURE;
                end
            end
            CAPTURE: begin
                mask_nx  = mask_cap;
                state_nx = (mask_cap == '0) ? IDLE : SCAN;
            end
            SCAN: begin
                if (hs) begin
                    mask_nx[out_idx] = 1'b0;
                    if (out_last) begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    mask_next_idx #(
        .N (NREGS),
        .W (IW)
    ) u_next (
        .mask     (mask_nx),
        .idx      (nx_idx),
        .found    (nx_found),
        .only_one (nx_one)
    );

    // During CAPTURE the shadow is still being loaded, so read the live file.
    assign nx_data = (state == CAPTURE) ? regs_a[nx_idx] : shadow[nx_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cyc       <= '0;
            dcnt      <= reload;
            cap_cycle <= '0;
            overruns  <= '0;
            primed    <= 1'b0;
            mask      <= '0;
            for (int i = 0; i < NREGS; i++) begin
                shadow[i] <= '0;
            end
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_cycle <= '0;
            out_idx   <= '0;
            out_data  <= '0;
        end else begin
            cyc <= cyc + CYC_W'(1);
            if (!en || dcnt == '0) begin
                dcnt <= reload;
            end else begin
                dcnt <= dcnt - CYC_W'(1);
            end
            if (trig && busy && overruns != '1) begin
                overruns <= overruns + OVF_W'(1);
            end
            if (state == IDLE && trig) begin
                cap_cycle <= cyc;
            end
            state <= state_nx;
            mask  <= mask_nx;
            if (state == CAPTURE) begin
                primed <= 1'b1;
                for (int i = 0; i < NREGS; i++) begin
                    shadow[i] <= regs_a[i];
                end
            end
            // Beat register only advances on capture or handshake: stalls hold it.
            if (state == CAPTURE || hs) begin
                out_valid <= nx_found;
                if (nx_found) begin
                    out_cycle <= cap_cycle;
                    out_idx   <= nx_idx;
                    out_data  <= nx_data;
                    out_last  <= nx_one;
                end
            end
        end
    end

endmodule
